// File: rtl/venus_pkg.sv
// rtl/venus_pkg.sv - shared widths, opcodes and decode helper for the venus core
package venus_pkg;
  localparam int WORD  = 32;
  localparam int W_OPR = 32;
  localparam int ADDR  = 8;

  typedef enum logic [5:0] {
    OP_NOP  = 6'h00,
    OP_ADD  = 6'h01,
    OP_SUB  = 6'h02,
    OP_AND  = 6'h03,
    OP_OR   = 6'h04,
    OP_XOR  = 6'h05,
    OP_SLL  = 6'h06,
    OP_SRL  = 6'h07,
    OP_ADDI = 6'h08,
    OP_LI   = 6'h09,
    OP_LD   = 6'h0A,
    OP_ST   = 6'h0B,
    OP_BEQ  = 6'h0C,
    OP_BNE  = 6'h0D,
    OP_JMP  = 6'h0E,
    OP_HLT  = 6'h3F
  } opcode_e;

  // Bit positions of the decoded-info vector carried from F to E
  localparam int W_INFO = 5;
  localparam int WRSV   = 0;
  localparam int BRF    = 1;
  localparam int LD     = 2;
  localparam int ST     = 3;
  localparam int HLT    = 4;

  function automatic logic [W_INFO-1:0] decode_info(input logic [5:0] op);
    logic [W_INFO-1:0] info;
    info = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_ADDI, OP_LI: info[WRSV] = 1'b1;
      OP_LD: begin
        info[WRSV] = 1'b1;
        info[LD]   = 1'b1;
      end
      OP_ST:                  info[ST]  = 1'b1;
      OP_BEQ, OP_BNE, OP_JMP: info[BRF] = 1'b1;
      OP_HLT:                 info[HLT] = 1'b1;
      default: ;
    endcase
    return info;
  endfunction
endpackage

// File: rtl/venus_regfile.sv
// rtl/venus_regfile.sv - 16 x W_OPR register file, two async reads, one sync write
module venus_regfile #(
  parameter int W_OPR = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [3:0]       ra_addr,
  output logic [W_OPR-1:0] ra_data,
  input  logic [3:0]       rb_addr,
  output logic [W_OPR-1:0] rb_data,
  input  logic             we,
  input  logic [3:0]       waddr,
  input  logic [W_OPR-1:0] wdata
);
  logic [W_OPR-1:0] regs_q [16];
  logic [W_OPR-1:0] regs_d [16];

  assign ra_data = regs_q[ra_addr];
  assign rb_data = regs_q[rb_addr];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) regs_q <= '{default: '0};
    else         regs_q <= regs_d;
  end
endmodule

// File: rtl/venus_core.sv
// rtl/venus_core.sv - two-stage in-order venus core: fetch/decode (F) then execute (E)
module venus_core #(
  parameter int WORD  = venus_pkg::WORD,
  parameter int W_OPR = venus_pkg::W_OPR,
  parameter int ADDR  = venus_pkg::ADDR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic [WORD-1:0]  inst_i,
  output logic [ADDR-1:0]  inst_addr_o,
  output logic [ADDR-1:0]  ldst_addr_o,
  output logic [W_OPR-1:0] ldst_data_o,
  input  logic [W_OPR-1:0] ldst_data_i,
  output logic             ldst_write_o,
  output logic             hlt_o
);
  import venus_pkg::*;

  typedef struct packed {
    logic              valid;
    logic [ADDR-1:0]   pc;
    logic [5:0]        op;
    logic [W_INFO-1:0] info;
    logic [W_OPR-1:0]  opr0;
    logic [W_OPR-1:0]  opr1;
    logic [15:0]       imm;
    logic [3:0]        rd;
  } fe_t;

  logic [ADDR-1:0]  pc_q, pc_d;
  fe_t              fe_q, fe_d;
  logic             hlt_q, hlt_d;

  logic [5:0]       f_op;
  logic [3:0]       f_rd, f_rs;
  logic [W_OPR-1:0] rf_rd_data, rf_rs_data, f_opr0, f_opr1;

  logic [W_OPR-1:0] e_sext, e_result;
  logic [ADDR-1:0]  e_target, e_addr;
  logic             e_eq, e_taken, e_hlt, e_we;

  logic unused_inst;
  assign unused_inst = ^inst_i[17:16];

  assign f_op = inst_i[31:26];
  assign f_rd = inst_i[25:22];
  assign f_rs = inst_i[21:18];

  venus_regfile #(.W_OPR(W_OPR)) u_rf (
    .clk     (clk),
    .resetn  (reset),
    .ra_addr (f_rd),
    .ra_data (rf_rd_data),
    .rb_addr (f_rs),
    .rb_data (rf_rs_data),
    .we      (e_we),
    .waddr   (fe_q.rd),
    .wdata   (e_result)
  );

  // Kept apart from the ALU so the load path through external memory is not a block-level loop
  assign e_addr   = fe_q.opr1[ADDR-1:0] + fe_q.imm[ADDR-1:0];
  assign e_target = fe_q.pc + fe_q.imm[ADDR-1:0];

  always_comb begin
    e_sext   = {{(W_OPR-16){fe_q.imm[15]}}, fe_q.imm};
    e_eq     = (fe_q.opr0 == fe_q.opr1);
    e_result = fe_q.opr0;
    case (fe_q.op)
      OP_ADD:  e_result = fe_q.opr0 + fe_q.opr1;
      OP_SUB:  e_result = fe_q.opr0 - fe_q.opr1;
      OP_AND:  e_result = fe_q.opr0 & fe_q.opr1;
      OP_OR:   e_result = fe_q.opr0 | fe_q.opr1;
      OP_XOR:  e_result = fe_q.opr0 ^ fe_q.opr1;
      OP_SLL:  e_result = fe_q.opr0 << fe_q.opr1[4:0];
      OP_SRL:  e_result = fe_q.opr0 >> fe_q.opr1[4:0];
      OP_ADDI: e_result = fe_q.opr0 + e_sext;
      OP_LI:   e_result = e_sext;
      default: ;
    endcase
    if (fe_q.info[LD]) e_result = ldst_data_i;
    e_taken = fe_q.valid && fe_q.info[BRF] &&
              ((fe_q.op == OP_JMP) || (fe_q.op == OP_BEQ && e_eq) || (fe_q.op == OP_BNE && !e_eq));
    e_hlt   = fe_q.valid && fe_q.info[HLT];
    e_we    = fe_q.valid && fe_q.info[WRSV] && !stall_i && !hlt_q;
  end

  // The instruction in E is about to write, so F must see its result instead of the stale register
  always_comb begin
    f_opr0 = rf_rd_data;
    f_opr1 = rf_rs_data;
    if (e_we && (fe_q.rd == f_rd)) f_opr0 = e_result;
    if (e_we && (fe_q.rd == f_rs)) f_opr1 = e_result;
  end

  always_comb begin
    pc_d = pc_q + ADDR'(1);
    if (!reset)                            pc_d = '0;
    else if (stall_i || hlt_q || e_hlt)    pc_d = pc_q;
    else if (e_taken)                      pc_d = e_target;

    fe_d = fe_q;
    if (!stall_i) begin
      fe_d.valid = !(e_taken || e_hlt || hlt_q);
      fe_d.pc    = pc_q;
      fe_d.op    = f_op;
      fe_d.info  = decode_info(f_op);
      fe_d.opr0  = f_opr0;
      fe_d.opr1  = f_opr1;
      fe_d.imm   = inst_i[15:0];
      fe_d.rd    = f_rd;
    end

    hlt_d = hlt_q || (e_hlt && !stall_i);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q  <= '0;
      fe_q  <= '0;
      hlt_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      fe_q  <= fe_d;
      hlt_q <= hlt_d;
    end
  end

  assign inst_addr_o  = pc_d;
  assign ldst_addr_o  = reset ? e_addr : '0;
  assign ldst_data_o  = reset ? fe_q.opr0 : '0;
  assign ldst_write_o = reset && fe_q.valid && fe_q.info[ST] && !stall_i && !hlt_q;
  assign hlt_o        = hlt_q;
endmodule

// File: tb/tb_venus_core.sv
// tb/tb_venus_core.sv - directed and random programs checked against an ISA-level interpreter
module tb_venus_core;
  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic [31:0] inst_q;
  logic [7:0]  inst_addr_o, ldst_addr_o;
  logic [31:0] ldst_data_o, ldst_data_i;
  logic        ldst_write_o, hlt_o;

  always #5 clk = ~clk;

  venus_core dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall_i),
    .inst_i       (inst_q),
    .inst_addr_o  (inst_addr_o),
    .ldst_addr_o  (ldst_addr_o),
    .ldst_data_o  (ldst_data_o),
    .ldst_data_i  (ldst_data_i),
    .ldst_write_o (ldst_write_o),
    .hlt_o        (hlt_o)
  );

  logic [31:0] imem  [256];
  logic [31:0] dmem  [256];
  logic [31:0] dinit [256];
  logic        load_dmem = 1'b0;
  int          wr_count = 0;

  always @(posedge clk) inst_q <= imem[inst_addr_o];
  assign ldst_data_i = dmem[ldst_addr_o];
  always @(posedge clk) begin
    if (load_dmem) dmem <= dinit;
    else if (ldst_write_o) begin
      dmem[ldst_addr_o] <= ldst_data_o;
      wr_count <= wr_count + 1;
    end
  end

  int          n_vec = 0;
  int          n_miss = 0;
  int          cycles, w0;
  logic [31:0] prog [$];

  logic [31:0] m_regs [16];
  logic [31:0] m_mem  [256];
  int          m_stores;

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [15:0] imm);
    return {op, rd, rs, 2'b00, imm};
  endfunction

  function automatic logic [31:0] dut_reg(input int i);
    return dut.u_rf.regs_q[i];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++)
      imem[i] = (i < prog.size()) ? prog[i] : enc(6'h3F, 4'd0, 4'd0, 16'd0);
  endtask

  // Instruction-at-a-time interpreter of the ISA; pipeline timing plays no part here
  task automatic model_run();
    int pc, nxt;
    logic [31:0] ins, a, b, sx;
    logic [5:0]  op;
    logic [3:0]  rd, rs;
    logic [7:0]  ad;
    bit          halted;
    for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    m_stores = 0;
    halted = 1'b0;
    pc = 0;
    for (int s = 0; s < 5000 && !halted; s++) begin
      ins = imem[pc];
      op = ins[31:26]; rd = ins[25:22]; rs = ins[21:18];
      sx = {{16{ins[15]}}, ins[15:0]};
      a = m_regs[rd]; b = m_regs[rs];
      ad = 8'(b + sx);
      nxt = (pc + 1) % 256;
      case (op)
        6'h01: m_regs[rd] = a + b;
        6'h02: m_regs[rd] = a - b;
        6'h03: m_regs[rd] = a & b;
        6'h04: m_regs[rd] = a | b;
        6'h05: m_regs[rd] = a ^ b;
        6'h06: m_regs[rd] = a << b[4:0];
        6'h07: m_regs[rd] = a >> b[4:0];
        6'h08: m_regs[rd] = a + sx;
        6'h09: m_regs[rd] = sx;
        6'h0A: m_regs[rd] = m_mem[ad];
        6'h0B: begin m_mem[ad] = a; m_stores++; end
        6'h0C: if (a == b) nxt = (pc + int'(sx)) & 255;
        6'h0D: if (a != b) nxt = (pc + int'(sx)) & 255;
        6'h0E: nxt = (pc + int'(sx)) & 255;
        6'h3F: halted = 1'b1;
        default: ;
      endcase
      pc = nxt;
    end
  endtask

  // mode 0: no stall, 1: 3-cycle stall on the first store in E, 2: random stalls
  task automatic run_dut(input int mode, input bit do_reset, output bit did_stall);
    did_stall = 1'b0;
    stall_i = 1'b0;
    if (do_reset) begin
      reset = 1'b0;
      load_dmem = 1'b1;
      @(negedge clk);
      load_dmem = 1'b0;
      @(negedge clk);
    end
    m_mem = dmem;
    reset = 1'b1;
    w0 = wr_count;
    cycles = 0;
    while (!hlt_o && cycles < BUDGET) begin
      if (mode == 1 && !did_stall && ldst_write_o) begin
        stall_i = 1'b1;
        #1;
        check("stall blocks store strobe", 32'(ldst_write_o), 32'd0);
        repeat (3) @(negedge clk);
        stall_i = 1'b0;
        did_stall = 1'b1;
        cycles += 3;
      end else begin
        if (mode == 2) stall_i = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        cycles++;
      end
    end
    stall_i = 1'b0;
    repeat (3) @(negedge clk);
    check("halt within cycle budget", 32'(cycles < BUDGET), 32'd1);
  endtask

  task automatic compare(input string tag);
    check({tag, " hlt_o"}, 32'(hlt_o), 32'd1);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s r%0d", tag, i), dut_reg(i), m_regs[i]);
    for (int i = 0; i < 256; i++)
      check($sformatf("%s mem[%0d]", tag, i), dmem[i], m_mem[i]);
    check({tag, " store pulses"}, 32'(wr_count - w0), 32'(m_stores));
  endtask

  task automatic gen_random(input int n);
    logic [5:0]  op;
    logic [3:0]  rd, rs;
    logic [15:0] imm;
    int          r;
    prog.delete();
    for (int i = 0; i < n - 1; i++) begin
      rd  = 4'($urandom_range(0, 15));
      rs  = 4'($urandom_range(0, 15));
      imm = 16'($urandom);
      r   = $urandom_range(0, 13);
      if (r <= 4)       op = 6'($urandom_range(1, 7));
      else if (r == 5)  op = 6'h09;
      else if (r == 6)  op = 6'h08;
      else if (r <= 8)  op = 6'h0A;
      else if (r == 9)  op = 6'h0B;
      else if (r == 10) begin
        op  = 6'($urandom_range(12, 14));
        imm = 16'($urandom_range(1, 4));
      end
      else if (r == 11) op = 6'($urandom_range(15, 62));
      else if (r == 12) op = 6'h09;
      else              op = 6'h00;
      prog.push_back(enc(op, rd, rs, imm));
    end
    prog.push_back(enc(6'h3F, 4'd0, 4'd0, 16'd0));
    for (int i = 0; i < 256; i++) dinit[i] = $urandom;
  endtask

  initial begin
    bit ds;
    reset = 1'b0;
    stall_i = 1'b0;
    for (int i = 0; i < 256; i++) dinit[i] = 32'd0;

    prog = '{enc(6'h09, 4'd1, 4'd0, 16'd5), enc(6'h09, 4'd2, 4'd0, 16'd7),
             enc(6'h01, 4'd1, 4'd2, 16'd0), enc(6'h02, 4'd2, 4'd1, 16'd0),
             enc(6'h3F, 4'd0, 4'd0, 16'd0)};
    load_prog();
    repeat (2) @(negedge clk);
    check("reset inst_addr_o", 32'(inst_addr_o), 32'd0);
    check("reset hlt_o", 32'(hlt_o), 32'd0);
    check("reset ldst_write_o", 32'(ldst_write_o), 32'd0);
    check("reset ldst_addr_o", 32'(ldst_addr_o), 32'd0);
    check("reset ldst_data_o", ldst_data_o, 32'd0);
    for (int i = 0; i < 16; i++) check($sformatf("reset r%0d", i), dut_reg(i), 32'd0);

    run_dut(0, 1'b1, ds);
    model_run();
    compare("alu");
    check("alu r1 const", dut_reg(1), 32'd12);
    check("alu r2 const", dut_reg(2), 32'hFFFF_FFFB);

    prog = '{enc(6'h09, 4'd3, 4'd0, 16'h1234), enc(6'h09, 4'd4, 4'd0, 16'd2),
             enc(6'h0B, 4'd3, 4'd4, 16'd1), enc(6'h0A, 4'd5, 4'd4, 16'd1),
             enc(6'h01, 4'd5, 4'd5, 16'd0), enc(6'h3F, 4'd0, 4'd0, 16'd0)};
    load_prog();
    run_dut(0, 1'b1, ds);
    model_run();
    compare("mem");
    check("mem mem[3] const", dmem[3], 32'h0000_1234);
    check("mem r5 const", dut_reg(5), 32'h0000_2468);

    run_dut(1, 1'b1, ds);
    model_run();
    compare("stall");
    check("stall applied", 32'(ds), 32'd1);
    check("stall single store pulse", 32'(wr_count - w0), 32'd1);

    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset inst_addr_o", 32'(inst_addr_o), 32'd0);
    check("midreset ldst_addr_o", 32'(ldst_addr_o), 32'd0);
    check("midreset ldst_data_o", ldst_data_o, 32'd0);
    @(negedge clk);
    check("midreset hlt_o", 32'(hlt_o), 32'd0);
    for (int i = 0; i < 16; i++) check($sformatf("midreset r%0d", i), dut_reg(i), 32'd0);
    run_dut(0, 1'b0, ds);
    model_run();
    compare("rerun");
    check("rerun r5 const", dut_reg(5), 32'h0000_2468);

    prog = '{enc(6'h09, 4'd1, 4'd0, 16'd1), enc(6'h0C, 4'd1, 4'd1, 16'd2),
             enc(6'h09, 4'd2, 4'd0, 16'd9), enc(6'h09, 4'd3, 4'd0, 16'd4),
             enc(6'h0D, 4'd1, 4'd1, 16'd5), enc(6'h3F, 4'd0, 4'd0, 16'd0)};
    load_prog();
    run_dut(0, 1'b1, ds);
    model_run();
    compare("branch");
    check("branch r2 const", dut_reg(2), 32'd0);
    check("branch r3 const", dut_reg(3), 32'd4);

    prog = '{enc(6'h09, 4'd1, 4'd0, 16'd10), enc(6'h09, 4'd2, 4'd0, 16'd0),
             enc(6'h08, 4'd2, 4'd0, 16'd3), enc(6'h08, 4'd1, 4'd0, 16'hFFFF),
             enc(6'h0D, 4'd1, 4'd6, 16'hFFFE), enc(6'h3F, 4'd0, 4'd0, 16'd0)};
    load_prog();
    run_dut(0, 1'b1, ds);
    model_run();
    compare("loop");
    check("loop r1 const", dut_reg(1), 32'd0);
    check("loop r2 const", dut_reg(2), 32'd30);

    for (int t = 0; t < 8; t++) begin
      gen_random(24);
      load_prog();
      run_dut((t % 2 == 1) ? 2 : 0, 1'b1, ds);
      model_run();
      compare($sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
